// File: rtl/wb_xbar_pkg.sv
// Shared types and constants for the round-robin Wishbone crossbar.
package wb_xbar_pkg;

  // Arbiter/decoder control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TOUT   = 2'd3
  } xbar_state_e;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index width for an n-entry vector, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_xbar_if.sv
// Bundled master-side and slave-side Wishbone signals of the crossbar.
interface wb_rr_xbar_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned NS = 4,
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32
);
  localparam int unsigned SW = DW / 8;

  // Master ports
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*DW-1:0] m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  // Slave ports
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic [2:0]       s_cti_o;
  logic             s_we_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic [NS-1:0]    s_err_i;
  logic [NS-1:0]    s_rty_i;

  // Grant status
  logic [NM-1:0]    gnt_o;

  // Crossbar view: a Wishbone slave to the masters, master to the slaves
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output gnt_o
  );

  // Fabric view: the masters and slaves attached around the crossbar
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  gnt_o
  );

endinterface

// File: rtl/wb_rr_grant.sv
// Round-robin picker: first requester after the last owner wins.
module wb_rr_grant
  import wb_xbar_pkg::*;
#(
  parameter  int unsigned NM = 2,
  localparam int unsigned IW = idx_width(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          vld_c
);

  logic [IW-1:0] cand;

  // Scan (last+1) .. (last+NM) modulo NM, take the first active request
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    vld_c = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = IW'((32'(last) + k) % NM);
      if (!vld_c && req[cand]) begin
        vld_c       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_xbar.sv
// Wishbone shared-bus crossbar: round-robin grant, base/mask decode,
// internal error responder for unmapped addresses and a stall watchdog.
module wb_rr_xbar
  import wb_xbar_pkg::*;
#(
  parameter int unsigned       NM      = 2,
  parameter int unsigned       NS      = 4,
  parameter int unsigned       DW      = 64,
  parameter int unsigned       AW      = 32,
  parameter logic [NS*AW-1:0]  S_BASE  = {NS{AW'(32'h0000_0000)}},
  parameter logic [NS*AW-1:0]  S_MASK  = {NS{AW'(32'hFFFF_F000)}},
  parameter int unsigned       TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rstn,
  wb_rr_xbar_if.slave  bus
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned IW  = idx_width(NM);
  localparam int unsigned SIW = idx_width(NS);
  localparam int unsigned CW  = idx_width(TIMEOUT + 1);

  xbar_state_e    state, state_nxt;
  logic [NM-1:0]  gnt_q, gnt_nxt;
  logic [IW-1:0]  gidx_q, gidx_nxt;
  logic [IW-1:0]  last_q, last_nxt;
  logic [SIW-1:0] sel_q, sel_nxt;
  logic           miss_q, miss_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;

  logic [NM-1:0]  pick_gnt_c;
  logic [IW-1:0]  pick_idx_c;
  logic           pick_vld_c;

  logic           g_cyc, g_stb, g_we;
  logic [AW-1:0]  g_adr;
  logic [DW-1:0]  g_dat;
  logic [SW-1:0]  g_sel;
  logic [2:0]     g_cti;

  logic           sl_ack, sl_err, sl_rty;
  logic [DW-1:0]  sl_dat;

  logic           hit_any_c;
  logic [SIW-1:0] hit_idx_c;
  logic           term_c, stall_c, expire_c;

  wb_rr_grant #(.NM(NM)) u_grant (
    .req   (bus.m_cyc_i),
    .last  (last_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .vld_c (pick_vld_c)
  );

  // Granted master's request and selected slave's response
  always_comb begin
    g_cyc  = bus.m_cyc_i[gidx_q];
    g_stb  = bus.m_stb_i[gidx_q];
    g_we   = bus.m_we_i[gidx_q];
    g_adr  = bus.m_adr_i[32'(gidx_q)*AW +: AW];
    g_dat  = bus.m_dat_i[32'(gidx_q)*DW +: DW];
    g_sel  = bus.m_sel_i[32'(gidx_q)*SW +: SW];
    g_cti  = bus.m_cti_i[32'(gidx_q)*3 +: 3];
    sl_ack = bus.s_ack_i[sel_q];
    sl_err = bus.s_err_i[sel_q];
    sl_rty = bus.s_rty_i[sel_q];
    sl_dat = bus.s_dat_i[32'(sel_q)*DW +: DW];
  end

  // Address decode; scanning downward lets the lowest-index hit win
  always_comb begin
    hit_any_c = 1'b0;
    hit_idx_c = '0;
    for (int i = int'(NS) - 1; i >= 0; i--) begin
      if ((g_adr & S_MASK[i*AW +: AW]) == (S_BASE[i*AW +: AW] & S_MASK[i*AW +: AW])) begin
        hit_any_c = 1'b1;
        hit_idx_c = SIW'(i);
      end
    end
  end

  // Watchdog qualifiers: expiry fires so the forced err lands on stall cycle TIMEOUT
  always_comb begin
    term_c   = (state == ST_ACTIVE) && (miss_q ? g_stb : (sl_ack || sl_err || sl_rty));
    stall_c  = (state == ST_ACTIVE) && g_cyc && g_stb && !term_c;
    expire_c = (TIMEOUT != 0) && stall_c && ((32'(cnt_q) + 32'd2) >= TIMEOUT);
  end

  // State and grant/decode/watchdog registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      last_q <= IW'(NM - 1);
      sel_q  <= '0;
      miss_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      gidx_q <= gidx_nxt;
      last_q <= last_nxt;
      sel_q  <= sel_nxt;
      miss_q <= miss_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Next-state: grant, decode once per cycle, hold until cyc drops
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    gidx_nxt  = gidx_q;
    last_nxt  = last_q;
    sel_nxt   = sel_q;
    miss_nxt  = miss_q;
    cnt_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (pick_vld_c) begin
          gnt_nxt   = pick_gnt_c;
          gidx_nxt  = pick_idx_c;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        sel_nxt   = hit_idx_c;
        miss_nxt  = !hit_any_c;
        state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!g_cyc) begin
          gnt_nxt   = '0;
          last_nxt  = gidx_q;
          state_nxt = ST_IDLE;
        end else begin
          if (stall_c) begin
            cnt_nxt = cnt_q + CW'(1);
          end
          if (expire_c) begin
            state_nxt = ST_TOUT;
          end
        end
      end
      ST_TOUT: begin
        if (!g_cyc) begin
          gnt_nxt   = '0;
          last_nxt  = gidx_q;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Bus routing: strobe only the selected slave, answer only the owner
  always_comb begin
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = CTI_CLASSIC;
    bus.s_we_o  = 1'b0;
    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.gnt_o   = gnt_q;
    if (state != ST_IDLE) begin
      bus.s_adr_o = g_adr;
      bus.s_dat_o = g_dat;
      bus.s_sel_o = g_sel;
      bus.s_cti_o = g_cti;
      bus.s_we_o  = g_we;
    end
    if (state == ST_ACTIVE) begin
      if (miss_q) begin
        bus.m_err_o[gidx_q] = g_stb;
      end else begin
        bus.s_cyc_o[sel_q]  = g_cyc;
        bus.s_stb_o[sel_q]  = g_stb;
        bus.m_ack_o[gidx_q] = sl_ack;
        bus.m_err_o[gidx_q] = sl_err;
        bus.m_rty_o[gidx_q] = sl_rty;
        bus.m_dat_o[32'(gidx_q)*DW +: DW] = sl_dat;
      end
    end else if (state == ST_TOUT) begin
      if (!miss_q) begin
        bus.s_cyc_o[sel_q] = g_cyc;
      end
      bus.m_err_o[gidx_q] = g_cyc;
    end
  end

endmodule

// File: tb/tb_wb_rr_xbar.sv
// Directed bench for wb_rr_xbar: 3 masters, 4 slaves, 16-cycle watchdog.
module tb_wb_rr_xbar;
  import wb_xbar_pkg::*;

  localparam int unsigned NM      = 3;
  localparam int unsigned NS      = 4;
  localparam int unsigned DW      = 64;
  localparam int unsigned AW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [NS*AW-1:0] S_BASE = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] S_MASK = {NS{32'hFFFF_F000}};

  localparam logic [63:0] D0 = 64'h1111_0000_1111_0000;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2 = 64'h3333_2222_3333_2222;
  localparam logic [63:0] D3 = 64'h4444_5555_4444_5555;

  logic clk = 1'b0;
  logic rstn;
  logic [NS-1:0] ack_en;
  int n_checks = 0;
  int n_errors = 0;

  wb_rr_xbar_if #(.NM(NM), .NS(NS), .DW(DW), .AW(AW)) bus ();

  wb_rr_xbar #(
    .NM(NM), .NS(NS), .DW(DW), .AW(AW),
    .S_BASE(S_BASE), .S_MASK(S_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Slave models: zero-wait ack while enabled, never err/rty
  always_comb begin
    bus.s_ack_i = bus.s_stb_o & ack_en;
    bus.s_err_i = '0;
    bus.s_rty_i = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[m]         = cyc;
    bus.m_stb_i[m]         = cyc;
    bus.m_adr_i[m*AW +: AW] = adr;
    bus.m_cti_i[m*3 +: 3]   = cti;
  endtask

  initial begin
    rstn         = 1'b0;
    ack_en       = '1;
    bus.m_cyc_i  = '1;
    bus.m_stb_i  = '1;
    bus.m_we_i   = '0;
    bus.m_adr_i  = '0;
    bus.m_dat_i  = '0;
    bus.m_sel_i  = '1;
    bus.m_cti_i  = '0;
    bus.s_dat_i  = {D3, D2, D1, D0};
    set_m(0, 1'b1, 32'h0000_0100, CTI_CLASSIC);
    set_m(1, 1'b1, 32'h0000_2010, CTI_CLASSIC);
    set_m(2, 1'b1, 32'h0000_3008, CTI_CLASSIC);

    // Reset held with every master requesting
    tick();
    tick();
    chk("rst_gnt",   64'(bus.gnt_o),   64'h0);
    chk("rst_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("rst_s_stb", 64'(bus.s_stb_o), 64'h0);
    chk("rst_ack",   64'(bus.m_ack_o), 64'h0);
    chk("rst_err",   64'(bus.m_err_o), 64'h0);
    chk("rst_rty",   64'(bus.m_rty_o), 64'h0);
    chk("rst_dat",   64'(|bus.m_dat_o), 64'h0);

    // Master 0 wins first; slave strobe two edges later
    rstn = 1'b1;
    tick();
    chk("gnt_m0",   64'(bus.gnt_o),   64'h1);
    chk("s_cyc_c1", 64'(bus.s_cyc_o), 64'h0);
    tick();
    chk("s_cyc_c2", 64'(bus.s_cyc_o), 64'h1);
    chk("ack_m0",   64'(bus.m_ack_o), 64'h1);
    chk("dat_m0",   bus.m_dat_o[63:0], D0);

    // Rotation 0 -> 1 -> 2 -> 0, one idle cycle between owners
    bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    tick();
    chk("idle_a",   64'(bus.gnt_o),   64'h0);
    chk("idle_a_s", 64'(bus.s_cyc_o), 64'h0);
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    tick();
    chk("gnt_m1", 64'(bus.gnt_o), 64'h2);
    tick();
    chk("s_cyc_m1",   64'(bus.s_cyc_o), 64'h2);
    chk("s_adr_m1",   64'(bus.s_adr_o), 64'h2010);
    chk("ack_m1",     64'(bus.m_ack_o), 64'h2);
    chk("dat_m1",     bus.m_dat_o[127:64], D1);
    chk("dat_m0_off", bus.m_dat_o[63:0], 64'h0);
    chk("dat_m2_off", bus.m_dat_o[191:128], 64'h0);
    bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0;
    tick();
    chk("idle_b", 64'(bus.gnt_o), 64'h0);
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    tick();
    chk("gnt_m2", 64'(bus.gnt_o), 64'h4);
    tick();
    chk("s_cyc_m2", 64'(bus.s_cyc_o), 64'h4);
    chk("dat_m2",   bus.m_dat_o[191:128], D2);
    bus.m_cyc_i[2] = 1'b0; bus.m_stb_i[2] = 1'b0;
    tick();
    chk("idle_c", 64'(bus.gnt_o), 64'h0);
    bus.m_cyc_i[2] = 1'b1; bus.m_stb_i[2] = 1'b1;
    tick();
    chk("gnt_wrap_m0", 64'(bus.gnt_o), 64'h1);

    // All masters withdraw during decode: empty pass, then idle
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    tick();
    chk("empty_gnt",   64'(bus.gnt_o),   64'h1);
    chk("empty_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    tick();
    chk("empty_idle",  64'(bus.gnt_o),   64'h0);

    // Unmapped address from master 1: internal err per strobe
    set_m(1, 1'b1, 32'hF000_0000, CTI_CLASSIC);
    tick();
    chk("gnt_miss", 64'(bus.gnt_o), 64'h2);
    tick();
    chk("miss_s_stb", 64'(bus.s_stb_o), 64'h0);
    chk("miss_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("miss_err1",  64'(bus.m_err_o), 64'h2);
    chk("miss_ack",   64'(bus.m_ack_o), 64'h0);
    chk("miss_dat",   64'(|bus.m_dat_o), 64'h0);
    bus.m_stb_i[1] = 1'b0;
    #1;
    chk("miss_no_stb", 64'(bus.m_err_o), 64'h0);
    tick();
    bus.m_stb_i[1] = 1'b1;
    #1;
    chk("miss_err2", 64'(bus.m_err_o), 64'h2);
    set_m(1, 1'b0, 32'hF000_0000, CTI_CLASSIC);
    tick();
    chk("miss_end_gnt", 64'(bus.gnt_o),   64'h0);
    chk("miss_end_err", 64'(bus.m_err_o), 64'h0);

    // Watchdog: slave 2 never acks, err forced on the 16th stalled cycle
    ack_en[2] = 1'b0;
    set_m(2, 1'b1, 32'h0000_3008, CTI_CLASSIC);
    tick();
    chk("gnt_wd", 64'(bus.gnt_o), 64'h4);
    tick();
    chk("wd_s_stb_1", 64'(bus.s_stb_o), 64'h4);
    chk("wd_quiet_1", 64'(bus.m_err_o), 64'h0);
    for (int k = 2; k <= 15; k++) begin
      tick();
      chk("wd_quiet", 64'(bus.m_err_o), 64'h0);
    end
    tick();
    chk("wd_err",   64'(bus.m_err_o), 64'h4);
    chk("wd_stb",   64'(bus.s_stb_o), 64'h0);
    chk("wd_cyc",   64'(bus.s_cyc_o), 64'h4);
    tick();
    chk("wd_rearm_err", 64'(bus.m_err_o), 64'h0);
    chk("wd_rearm_stb", 64'(bus.s_stb_o), 64'h4);
    ack_en[2] = 1'b1;
    #1;
    chk("wd_late_ack", 64'(bus.m_ack_o), 64'h4);
    set_m(2, 1'b0, 32'h0000_3008, CTI_CLASSIC);
    tick();
    chk("wd_end_gnt", 64'(bus.gnt_o), 64'h0);

    // INCR burst from master 0 is not preempted by master 1
    set_m(0, 1'b1, 32'h0000_0100, CTI_INCR);
    set_m(1, 1'b1, 32'h0000_2010, CTI_CLASSIC);
    tick();
    chk("gnt_burst", 64'(bus.gnt_o), 64'h1);
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) bus.m_cti_i[2:0] = CTI_EOB;
      tick();
      chk("burst_gnt", 64'(bus.gnt_o),   64'h1);
      chk("burst_ack", 64'(bus.m_ack_o), 64'h1);
      chk("burst_cti", 64'(bus.s_cti_o), (b == 4) ? 64'(CTI_EOB) : 64'(CTI_INCR));
      bus.m_adr_i[31:0] = bus.m_adr_i[31:0] + 32'd8;
    end
    set_m(0, 1'b0, 32'h0000_0100, CTI_CLASSIC);
    tick();
    chk("burst_idle", 64'(bus.gnt_o), 64'h0);
    tick();
    chk("gnt_m1_after", 64'(bus.gnt_o), 64'h2);
    tick();
    chk("s_cyc_m1_after", 64'(bus.s_cyc_o), 64'h2);

    // Asynchronous reset mid-transfer clears everything without a termination
    rstn = 1'b0;
    #1;
    chk("arst_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("arst_ack",   64'(bus.m_ack_o), 64'h0);
    chk("arst_gnt",   64'(bus.gnt_o),   64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_xbar.md
# wb_rr_xbar

Parametrised Wishbone shared-bus arbiter/decoder connecting NM masters to NS slaves, the next generation of the 2-master/4-slave arbiter. Provides fair round-robin grant, per-slave base/mask address decode, an internal error responder for unmapped addresses, and a per-transfer watchdog that terminates hung slaves with err. Sits between the PCIe/SGDMA masters and the on-chip slave fabric.

## Interface
- NM, 2: number of masters (2..8)
- NS, 4: number of slaves (1..8)
- DW, 64: data width; sel width DW/8
- AW, 32: address width
- S_BASE, {NS{32'h0}}: packed NS×AW slave base addresses, slave i at [i*AW +: AW]
- S_MASK, {NS{32'hFFFF_F000}}: packed NS×AW decode masks; slave i hit when (adr & mask_i) == (base_i & mask_i)
- TIMEOUT, 255: stalled-strobe cycles before forced err; 0 disables watchdog
- clk  in  1  clock; all logic rising-edge
- rstn  in  1  reset; asynchronous, active-low
- m_cyc_i, m_stb_i, m_we_i  in  NM  per-master controls
- m_adr_i  in  NM×AW;  m_dat_i  in  NM×DW;  m_sel_i  in  NM×DW/8;  m_cti_i  in  NM×3
- m_dat_o  out  NM×DW  read data, zero for non-granted masters
- m_ack_o, m_err_o, m_rty_o  out  NM  terminations, only to granted master
- s_cyc_o, s_stb_o  out  NS  asserted only toward the selected slave
- s_adr_o  out  AW;  s_dat_o  out  DW;  s_sel_o  out  DW/8;  s_cti_o  out  3;  s_we_o  out  1  broadcast from granted master
- s_dat_i  in  NS×DW;  s_ack_i, s_err_i, s_rty_i  in  NS  slave responses
- gnt_o  out  NM  one-hot current grant (debug/status)

## Operation
- States: IDLE, DECODE, ACTIVE, TOUT.
- IDLE: no grant, all s_cyc/s_stb low. If any m_cyc_i high, pick winner by round-robin starting at (last+1) mod NM, register gnt, go DECODE.
- DECODE (1 cycle): register slave select from granted master's address; lowest-index hit wins on overlap; no hit sets miss flag. Go ACTIVE.
- ACTIVE: s_cyc/s_stb of selected slave = granted m_cyc/m_stb; selected slave's dat/ack/err/rty routed to granted master. Select held for the whole cyc; address changes mid-cycle are not re-decoded.
- Miss: no slave strobed; m_err_o = granted m_stb_i (one err per beat); m_dat_o = 0.
- Watchdog: counter clears on any ack/err/rty or stb low; increments while stb high and no termination. At count TIMEOUT-1 go TOUT.
- TOUT (1 cycle): m_err_o pulsed to granted master, s_stb_o forced low; counter cleared; return ACTIVE.
- Granted m_cyc_i low in ACTIVE or TOUT: go IDLE, last <= granted index. Grant never preempted mid-cycle, including bursts (cti 001/010) until cti 111 and cyc drop.
- rty from slave passed through unchanged; no retry by arbiter.

## Timing
- Reset: state IDLE, gnt_o 0, last = NM-1 (master 0 highest priority first), counter 0, all s_cyc/s_stb/m_ack/m_err/m_rty 0, m_dat_o 0.
- m_cyc rise to s_cyc: 2 cycles (grant register, decode register). Slave to master response: combinational, 0 cycles.
- Back-to-back: cyc drop -> IDLE one cycle -> next grant; minimum 1 dead cycle between owners.
- Simultaneous requests: grant to next index after last; a master dropping cyc in the grant cycle still gets a (empty) DECODE/ACTIVE pass, then IDLE.
- Slave ack coincident with watchdog expiry: ack wins, no TOUT.
- Reset mid-transfer: outputs clear asynchronously; masters see no termination.

## Structure
- Package wb_xbar_pkg: state enum, CTI constants (CLASSIC 000, CONST 001, INCR 010, EOB 111), clog2-based index widths.
- Sub-module wb_rr_grant: NM-wide round-robin picker (req, last pointer -> one-hot grant + index). Decode and watchdog inline.

## Test plan
- Reset with all m_cyc high -> all outputs 0; after release master 0 granted, s_cyc at cycle 2.
- NM=3, masters 0,1,2 requesting continuously, each single-beat cycle -> grant order 0,1,2,0 with 1 idle cycle between.
- Master 1 read 0x0000_2010 with S_BASE[1]=0x2000, mask 0xFFFF_F000 -> only s_cyc[1] asserted, slave data 0xDEAD_BEEF_0123_4567 returned to m_dat_o[1], others 0.
- Access to unmapped 0xF000_0000 -> no s_stb, m_err pulses per stb, cycle ends cleanly.
- Slave never acks, TIMEOUT=16 -> m_err at 16th stalled cycle, s_stb low that cycle.
- 4-beat INCR burst from master 0 while master 1 requests -> no preemption; master 1 granted only after master 0 drops cyc.
